dsp_mac_pipe: RTL

- Parametrised signed pre-add / multiply / post-add slice with a configurable multiplier pipeline depth.
- Adds a valid/ready stream handshake with global stall, an accumulator, saturation, overflow flag and pattern detect.
- Sits in the DSP datapath as the streaming replacement for the fixed 18x18/48 slice.
- Slices cascade through PCOUT -> PCIN.

---
 rtl/dsp_mac_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dsp_mac_pipe.sv
// Signed pre-add/multiply/post-add slice with accumulator, saturation and pattern detect.
// Latency M_STAGES+2 cycles, one beat per cycle; a single global advance stalls every stage while the result is unconsumed.
module dsp_mac_pipe #(
    parameter int A_WIDTH  = 18,
    parameter int B_WIDTH  = 18,
    parameter int P_WIDTH  = 48,
    parameter int C_WIDTH  = 48,
    parameter int M_STAGES = 2,
    parameter int SATURATE = 1,
    parameter logic [P_WIDTH-1:0] PATTERN = '0
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic signed [A_WIDTH-1:0]   A,
    input  logic signed [B_WIDTH-1:0]   B,
    input  logic signed [B_WIDTH-1:0]   D,
    input  logic signed [C_WIDTH-1:0]   C,
    input  logic        [4:0]           OP,
    input  logic signed [P_WIDTH-1:0]   PCIN,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic signed [P_WIDTH-1:0]   P,
    output logic signed [P_WIDTH-1:0]   PCOUT,
    output logic                        OVERFLOW,
    output logic                        PATTERN_DETECT
);
    localparam int PRE_W  = B_WIDTH + 1;
    localparam int PROD_W = A_WIDTH + B_WIDTH + 1;
    localparam int EXT_W  = P_WIDTH + 2;
    localparam logic signed [P_WIDTH-1:0] P_MAX = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};

    logic                        advance;
    logic                        s0_vld_q;
    logic signed [A_WIDTH-1:0]   s0_a_q;
    logic signed [B_WIDTH-1:0]   s0_b_q;
    logic signed [B_WIDTH-1:0]   s0_d_q;
    logic signed [C_WIDTH-1:0]   s0_c_q;
    logic        [4:0]           s0_op_q;

    logic signed [PRE_W-1:0]     pre_sum;
    logic signed [PRE_W-1:0]     mul_b;
    logic signed [PROD_W-1:0]    prod;

    logic        [M_STAGES-1:0]  mv_q;
    logic signed [PROD_W-1:0]    m_q   [M_STAGES];
    logic signed [C_WIDTH-1:0]   mc_q  [M_STAGES];
    logic        [4:0]           mop_q [M_STAGES];

    logic                        fin_vld;
    logic        [4:0]           fin_op;
    logic signed [EXT_W-1:0]     m_ext;
    logic signed [EXT_W-1:0]     c_ext;
    logic signed [EXT_W-1:0]     acc_ext;
    logic signed [EXT_W-1:0]     sum;
    logic signed [P_WIDTH-1:0]   p_d;
    logic                        ovf_d;
    logic                        pat_d;

    logic                        out_vld_q;
    logic signed [P_WIDTH-1:0]   p_q;
    logic                        ovf_q;
    logic                        pat_q;

    assign advance  = !out_vld_q || OUT_READY;
    assign IN_READY = advance;

    always_comb begin
        pre_sum = s0_op_q[4] ? (PRE_W'(s0_d_q) - PRE_W'(s0_b_q))
                             : (PRE_W'(s0_d_q) + PRE_W'(s0_b_q));
        mul_b   = s0_op_q[3] ? pre_sum : PRE_W'(s0_b_q);
        prod    = PROD_W'(s0_a_q) * PROD_W'(mul_b);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s0_vld_q <= 1'b0;
            s0_a_q   <= '0;
            s0_b_q   <= '0;
            s0_d_q   <= '0;
            s0_c_q   <= '0;
            s0_op_q  <= '0;
            mv_q     <= '0;
            for (int i = 0; i < M_STAGES; i++) begin
                m_q[i]   <= '0;
                mc_q[i]  <= '0;
                mop_q[i] <= '0;
            end
        end else if (advance) begin
            s0_vld_q <= IN_VALID;
            s0_a_q   <= A;
            s0_b_q   <= B;
            s0_d_q   <= D;
            s0_c_q   <= C;
            s0_op_q  <= OP;
            mv_q[0]  <= s0_vld_q;
            m_q[0]   <= prod;
            mc_q[0]  <= s0_c_q;
            mop_q[0] <= s0_op_q;
            for (int i = 1; i < M_STAGES; i++) begin
                mv_q[i]  <= mv_q[i-1];
                m_q[i]   <= m_q[i-1];
                mc_q[i]  <= mc_q[i-1];
                mop_q[i] <= mop_q[i-1];
            end
        end
    end

    // Post-add is evaluated two bits wider than P so any overflow is visible in the top bits.
    always_comb begin
        fin_vld = mv_q[M_STAGES-1];
        fin_op  = mop_q[M_STAGES-1];
        m_ext   = EXT_W'(m_q[M_STAGES-1]);
        c_ext   = EXT_W'(mc_q[M_STAGES-1]);
        acc_ext = EXT_W'(p_q);
        case (fin_op[2:0])
            3'b000:  sum = m_ext;
            3'b001:  sum = acc_ext + m_ext;
            3'b010:  sum = acc_ext - m_ext;
            3'b011:  sum = c_ext + m_ext;
            3'b100:  sum = c_ext - m_ext;
            3'b101:  sum = EXT_W'(PCIN) + m_ext;
            3'b110:  sum = acc_ext + c_ext;
            default: sum = '0;
        endcase
        ovf_d = !((&sum[EXT_W-1:P_WIDTH-1]) || !(|sum[EXT_W-1:P_WIDTH-1]));
        if (ovf_d && (SATURATE != 0)) begin
            p_d = sum[EXT_W-1] ? P_MIN : P_MAX;
        end else begin
            p_d = sum[P_WIDTH-1:0];
        end
        pat_d = ($unsigned(p_d) == PATTERN);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_vld_q <= 1'b0;
            p_q       <= '0;
            ovf_q     <= 1'b0;
            pat_q     <= 1'b0;
        end else if (advance) begin
            out_vld_q <= fin_vld;
            if (fin_vld) begin
                p_q   <= p_d;
                ovf_q <= ovf_d;
                pat_q <= pat_d;
            end
        end
    end

    assign OUT_VALID      = out_vld_q;
    assign P              = p_q;
    assign PCOUT          = p_q;
    assign OVERFLOW       = ovf_q;
    assign PATTERN_DETECT = pat_q;

endmodule
